// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core
// load/store unit (c_*) and the debug/program-loader port (d_*).
// Each access is a one-cycle command phase, plus a fixed read wait of
// RD_LAT cycles for loads.
// Optional build macro DMEM_ARB_RR_EN: round-robin on simultaneous
// requests. Without it, the core has fixed priority over debug.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_wr,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("dmem_arbiter: RD_LAT must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RWAIT = 2'd2} state_t;

  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_DBG  = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              c_gnt_q, c_gnt_d, c_rvalid_q, c_rvalid_d;
  logic              d_gnt_q, d_gnt_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
  logic              m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              busy_q, busy_d;

  logic              cReqEff, dReqEff, pickDbg, issue, capture;

`ifdef DMEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  // A requester whose read data is being returned this cycle still holds
  // req; ignore it for one cycle so the finished load is not reissued.
  always_comb begin
    cReqEff = c_req & ~c_rvalid_q;
    dReqEff = d_req & ~d_rvalid_q;
`ifdef DMEM_ARB_RR_EN
    pickDbg = dReqEff & (~cReqEff | (last_q == OWN_CORE));
`else
    pickDbg = dReqEff & ~cReqEff;
`endif
  end

`ifdef DMEM_ARB_RR_EN
  // Remember who won the most recent grant so a tie goes to the other side.
  assign last_d = (state_q == IDLE && (cReqEff || dReqEff)) ? pickDbg : last_q;

  // Last-owner register starts at debug so the core takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= OWN_DBG;
    else       last_q <= last_d;
  end
`endif

  // State and latched-command register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cReqEff || dReqEff) begin
          state_d = CMD;
          owner_d = pickDbg;
          we_d    = pickDbg ? d_we    : c_we;
          addr_d  = pickDbg ? d_addr  : c_addr;
          wdata_d = pickDbg ? d_wdata : c_wdata;
        end
      end
      CMD: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RWAIT;
          cnt_d   = CNT_INIT;
        end
      end
      RWAIT: begin
        if (cnt_q == 2'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: compute next values of the registered outputs so the
  // command strobes line up with the CMD cycle itself.
  always_comb begin
    issue      = (state_d == CMD);
    capture    = (state_q == RWAIT) && (cnt_q == 2'd0);
    m_wr_d     = issue & we_d;
    m_rd_d     = issue & ~we_d;
    m_addr_d   = issue ? addr_d  : '0;
    m_wdata_d  = issue ? wdata_d : '0;
    c_gnt_d    = issue & (owner_d == OWN_CORE);
    d_gnt_d    = issue & (owner_d == OWN_DBG);
    c_rvalid_d = capture & (owner_q == OWN_CORE);
    d_rvalid_d = capture & (owner_q == OWN_DBG);
    c_rdata_d  = c_rvalid_d ? m_rdata : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? m_rdata : d_rdata_q;
    busy_d     = (state_d != IDLE);
  end

  // Output register; reset clears everything, dropping any in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_gnt_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      m_wr_q     <= 1'b0;
      m_rd_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      c_gnt_q    <= c_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_gnt_q    <= d_gnt_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      m_wr_q     <= m_wr_d;
      m_rd_q     <= m_rd_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign c_gnt    = c_gnt_q;
  assign c_rvalid = c_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_gnt    = d_gnt_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign m_wr     = m_wr_q;
  assign m_rd     = m_rd_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign busy     = busy_q;

  // Stall clears as soon as the core's access is done: write grant or read data.
  assign c_stall = c_req & ~(c_gnt_q & c_we) & ~c_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// memory of RD_LAT cycles read latency. Expected grant order adapts to
// the DMEM_ARB_RR_EN build macro.
module tb_dmem_arbiter;

  localparam int RD_LAT = 3;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk, reset;
  logic        c_req, c_we, c_gnt, c_rvalid, c_stall;
  logic [8:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        m_wr, m_rd, busy;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: read data appears RD_LAT cycles after m_rd.
  logic [31:0] mem [0:511];
  logic [31:0] rdPipe [0:RD_LAT-1];
  assign m_rdata = rdPipe[RD_LAT-1];

  always @(posedge clk) begin
    if (m_wr) mem[m_addr] <= m_wdata;
    rdPipe[0] <= m_rd ? mem[m_addr] : 32'h0;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  // Hard time limit so a hung handshake still ends the run.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue a write from one port and wait (bounded) for its grant.
  task automatic doWrite(input bit dbg, input logic [8:0] addr, input logic [31:0] data,
                         output bit ok);
    ok = 1'b0;
    if (dbg) begin d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data; end
    else     begin c_req = 1'b1; c_we = 1'b1; c_addr = addr; c_wdata = data; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((dbg ? d_gnt : c_gnt) === 1'b1) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    if (dbg) d_req = 1'b0; else c_req = 1'b0;
  endtask

  // Issue a read from one port; report data and gnt-to-rvalid distance.
  task automatic doRead(input bit dbg, input logic [8:0] addr, output logic [31:0] data,
                        output int lat);
    bit gotGnt;
    gotGnt = 1'b0;
    lat = -1;
    data = 32'h0;
    if (dbg) begin d_req = 1'b1; d_we = 1'b0; d_addr = addr; end
    else     begin c_req = 1'b1; c_we = 1'b0; c_addr = addr; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((dbg ? d_gnt : c_gnt) === 1'b1) begin gotGnt = 1'b1; break; end
    end
    if (gotGnt) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if ((dbg ? d_rvalid : c_rvalid) === 1'b1) begin
          lat = k;
          data = dbg ? d_rdata : c_rdata;
          break;
        end
      end
    end
    if (dbg) d_req = 1'b0; else c_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    checks++;
    if ({c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, m_wr, m_rd, busy} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000000",
               {c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, m_wr, m_rd, busy});
    end
    checks++;
    if ({c_rdata, d_rdata, m_wdata, m_addr} !== 105'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got c_rdata=%h d_rdata=%h m_wdata=%h m_addr=%h expected all 0",
               c_rdata, d_rdata, m_wdata, m_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_core_write;
    logic [31:0] rd;
    int lat;
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h005; c_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({c_stall, c_gnt, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL cwr_request_cycle: got stall/gnt/busy=%b expected 100", {c_stall, c_gnt, busy});
    end
    @(negedge clk);
    checks++;
    if ({m_wr, m_rd, c_gnt, d_gnt, busy, c_stall} !== 6'b101010) begin
      errors++;
      $display("[TB] FAIL cwr_cmd_flags: got wr/rd/cg/dg/busy/stall=%b expected 101010",
               {m_wr, m_rd, c_gnt, d_gnt, busy, c_stall});
    end
    checks++;
    if (m_addr !== 9'h005 || m_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL cwr_cmd_bus: got addr=%h data=%h expected 005 deadbeef", m_addr, m_wdata);
    end
    @(negedge clk);
    c_req = 1'b0;
    checks++;
    if ({m_wr, c_gnt, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL cwr_after: got wr/gnt/busy=%b expected 000", {m_wr, c_gnt, busy});
    end
    doRead(1'b1, 9'h005, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != RD_LAT + 1) begin
      errors++;
      $display("[TB] FAIL cwr_readback: got data=%h lat=%0d expected deadbeef lat=%0d", rd, lat, RD_LAT + 1);
    end
  endtask

  task automatic test_core_read;
    bit ok;
    doWrite(1'b1, 9'h030, 32'h12345678, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL crd_preload: got no d_gnt expected d_gnt");
    end
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h030;
    #1;
    checks++;
    if (c_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL crd_stall_req: got %b expected 1", c_stall);
    end
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      @(negedge clk);
      checks++;
      if ({c_gnt, m_rd, c_rvalid, c_stall} !== {k == 1, k == 1, k == RD_LAT + 2, k <= RD_LAT + 1}) begin
        errors++;
        $display("[TB] FAIL crd_cycle%0d: got gnt/rd/rvalid/stall=%b expected %b", k,
                 {c_gnt, m_rd, c_rvalid, c_stall},
                 {k == 1, k == 1, k == RD_LAT + 2, k <= RD_LAT + 1});
      end
      if (k == 1) begin
        checks++;
        if (m_addr !== 9'h030) begin
          errors++;
          $display("[TB] FAIL crd_addr: got %h expected 030", m_addr);
        end
      end
      if (k == RD_LAT + 2) begin
        checks++;
        if (c_rdata !== 32'h12345678) begin
          errors++;
          $display("[TB] FAIL crd_data: got %h expected 12345678", c_rdata);
        end
        c_req = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (c_rvalid !== 1'b0 || c_rdata !== 32'h12345678 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL crd_hold: got rvalid=%b data=%h busy=%b expected 0 12345678 0",
               c_rvalid, c_rdata, busy);
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    logic [31:0] rd;
    int lat;
    logic [8:0]  expAddr;
    logic [31:0] expData;
    doWrite(1'b1, 9'h010, 32'hA5A50010, ok);
    doWrite(1'b1, 9'h011, 32'hA5A50011, ok);
    // Tie between a core read and a debug write, twice in a row.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 9'h010 + 9'(r);
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'h020 + 9'(r); d_wdata = 32'hCAFE0020 + 32'(r);
      for (int k = 1; k <= RD_LAT + 3; k++) begin
        @(negedge clk);
        checks++;
        if ({c_gnt, c_rvalid, d_gnt, c_stall} !==
            {k == 1, k == RD_LAT + 2, k == RD_LAT + 3, k <= RD_LAT + 1}) begin
          errors++;
          $display("[TB] FAIL tie%0d_cycle%0d: got cg/cv/dg/stall=%b expected %b", r, k,
                   {c_gnt, c_rvalid, d_gnt, c_stall},
                   {k == 1, k == RD_LAT + 2, k == RD_LAT + 3, k <= RD_LAT + 1});
        end
        if (k == RD_LAT + 2) begin
          checks++;
          if (c_rdata !== 32'hA5A50010 + 32'(r)) begin
            errors++;
            $display("[TB] FAIL tie%0d_rdata: got %h expected %h", r, c_rdata, 32'hA5A50010 + 32'(r));
          end
          c_req = 1'b0;
        end
        if (k == RD_LAT + 3) begin
          checks++;
          if (m_wr !== 1'b1 || m_addr !== 9'h020 + 9'(r) || m_wdata !== 32'hCAFE0020 + 32'(r)) begin
            errors++;
            $display("[TB] FAIL tie%0d_dwrite: got wr=%b addr=%h data=%h", r, m_wr, m_addr, m_wdata);
          end
          d_req = 1'b0;
        end
      end
    end
    for (int r = 0; r < 2; r++) begin
      doRead(1'b1, 9'h020 + 9'(r), rd, lat);
      checks++;
      if (rd !== 32'hCAFE0020 + 32'(r)) begin
        errors++;
        $display("[TB] FAIL tie_landed%0d: got %h expected %h", r, rd, 32'hCAFE0020 + 32'(r));
      end
    end
    // Core issues two writes back to back while debug waits.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h040; c_wdata = 32'h11;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h041; d_wdata = 32'h22;
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt} !== 2'b10 || m_addr !== 9'h040) begin
      errors++;
      $display("[TB] FAIL pri_first: got cg/dg=%b addr=%h expected 10 040", {c_gnt, d_gnt}, m_addr);
    end
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL pri_idle: got cg/dg/busy=%b expected 000", {c_gnt, d_gnt, busy});
    end
    c_addr = 9'h042; c_wdata = 32'h33;
    @(negedge clk);
    expAddr = RR_MODE ? 9'h041 : 9'h042;
    checks++;
    if ({c_gnt, d_gnt} !== {~RR_MODE, RR_MODE} || m_addr !== expAddr) begin
      errors++;
      $display("[TB] FAIL pri_second: got cg/dg=%b addr=%h expected %b %h",
               {c_gnt, d_gnt}, m_addr, {~RR_MODE, RR_MODE}, expAddr);
    end
    @(negedge clk);
    if (RR_MODE) d_req = 1'b0; else c_req = 1'b0;
    @(negedge clk);
    expAddr = RR_MODE ? 9'h042 : 9'h041;
    expData = RR_MODE ? 32'h33 : 32'h22;
    checks++;
    if ({c_gnt, d_gnt} !== {RR_MODE, ~RR_MODE} || m_addr !== expAddr || m_wdata !== expData) begin
      errors++;
      $display("[TB] FAIL pri_third: got cg/dg=%b addr=%h data=%h expected %b %h %h",
               {c_gnt, d_gnt}, m_addr, m_wdata, {RR_MODE, ~RR_MODE}, expAddr, expData);
    end
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      doRead(1'b1, 9'h040 + 9'(i), rd, lat);
      checks++;
      if (rd !== 32'h11 * 32'(i + 1)) begin
        errors++;
        $display("[TB] FAIL pri_landed%0d: got %h expected %h", i, rd, 32'h11 * 32'(i + 1));
      end
    end
  endtask

  task automatic test_reset_midread;
    logic [31:0] rd;
    int lat;
    bit gotGnt;
    gotGnt = 1'b0;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h030;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_gnt === 1'b1) begin gotGnt = 1'b1; break; end
    end
    checks++;
    if (!gotGnt) begin
      errors++;
      $display("[TB] FAIL rst_gnt: got no c_gnt expected c_gnt");
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    c_req = 1'b0;
    #1;
    checks++;
    if ({c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, m_wr, m_rd, busy} !== 8'h00 ||
        {c_rdata, d_rdata, m_wdata, m_addr} !== 105'h0) begin
      errors++;
      $display("[TB] FAIL rst_async: got flags=%b c_rdata=%h d_rdata=%h m_addr=%h expected all 0",
               {c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, m_wr, m_rd, busy}, c_rdata, d_rdata, m_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      @(negedge clk);
      checks++;
      if ({c_rvalid, d_rvalid, busy} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL rst_no_rvalid%0d: got cv/dv/busy=%b expected 000", k, {c_rvalid, d_rvalid, busy});
      end
    end
    doRead(1'b1, 9'h030, rd, lat);
    checks++;
    if (rd !== 32'h12345678 || lat != RD_LAT + 1 || c_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_fresh_read: got data=%h lat=%0d c_rdata=%h expected 12345678 %0d 0",
               rd, lat, c_rdata, RD_LAT + 1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h000; d_wdata = 32'hB0B00000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({d_gnt, m_wr, busy, c_gnt} !== {k[0], k[0], k[0], 1'b0}) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: got dg/wr/busy/cg=%b expected %b", k,
                 {d_gnt, m_wr, busy, c_gnt}, {k[0], k[0], k[0], 1'b0});
      end
      if (k[0]) begin
        checks++;
        if (m_addr !== 9'((k - 1) / 2) || m_wdata !== 32'hB0B00000 + 32'((k - 1) / 2)) begin
          errors++;
          $display("[TB] FAIL b2b_bus%0d: got addr=%h data=%h expected %h %h", k, m_addr, m_wdata,
                   9'((k - 1) / 2), 32'hB0B00000 + 32'((k - 1) / 2));
        end
      end else if (k < 8) begin
        d_addr = 9'(k / 2);
        d_wdata = 32'hB0B00000 + 32'(k / 2);
      end else begin
        d_req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      doRead(1'b1, 9'(i), rd, lat);
      checks++;
      if (rd !== 32'hB0B00000 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL b2b_mem%0d: got %h expected %h", i, rd, 32'hB0B00000 + 32'(i));
      end
    end
  endtask

  // Scenario sequence, then the summary line.
  initial begin
    test_reset();
    test_core_write();
    test_core_read();
    test_simultaneous();
    test_reset_midread();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (wr/rd/addr/wr_data/rd_data) between two requesters: core datapath load/store unit (port c_*) and debug/program-loader port (port d_*).
- Sequences each access as command phase plus fixed-latency read wait.
- Returns read data and completion to the winning requester.
- Drives a stall flag back to the datapath controller while a core access is pending.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 9, memory word address width.
- RD_LAT, 1, memory read latency in cycles from m_rd to valid m_rdata; legal range 1..4, elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  core request, level, held until done.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  one-cycle pulse: core command issued to memory.
- c_rvalid  out  1  one-cycle pulse: core read data valid.
- c_rdata  out  DATA_W  core read data.
- c_stall  out  1  core access pending, not yet done.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug request, same rules as core.
- d_gnt, d_rvalid  out  1  debug grant / read-valid pulses.
- d_rdata  out  DATA_W  debug read data.
- m_wr  out  1  memory write strobe.
- m_rd  out  1  memory read strobe.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; owner=core; all outputs 0; any in-flight read is discarded with no rvalid.
- All outputs except c_stall are registered.
- Request rules:
  - Requester holds req/we/addr/wdata stable until done (write: gnt pulse; read: rvalid pulse).
  - In the cycle after done, requester deasserts req or presents a new request.
- FSM states:
  - IDLE: if c_req|d_req, pick winner, latch owner/we/addr/wdata, go to CMD. Otherwise stay.
  - CMD (1 cycle): m_wr=we or m_rd=~we; m_addr/m_wdata = latched values; owner's gnt=1. Write goes to IDLE. Read goes to RWAIT with cnt=RD_LAT-1.
  - RWAIT: if cnt==0, capture m_rdata into owner's rdata, pulse owner's rvalid next cycle, go to IDLE; else decrement cnt.
- rvalid timing: rvalid rises RD_LAT+1 cycles after gnt.
- Throughput:
  - Write: 2 cycles per access.
  - Read: RD_LAT+2 cycles per access.
  - Requests are never evaluated outside IDLE.
- c_rdata/d_rdata hold their last value until the next rvalid for that port.
- c_stall = c_req & ~(c_gnt & c_we) & ~c_rvalid (combinational).
- Simultaneous c_req and d_req in IDLE: arbitration policy below; loser waits, req held.
- Requests arriving while FSM is busy wait; no queuing, no dropping.
- m_wr and m_rd are never both 1; at most one of c_gnt/d_gnt per cycle.
- Arbitration (default): fixed priority, core over debug. Debug may starve while core issues back-to-back accesses.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin. On simultaneous requests, the requester that did not own the previous grant wins; last-owner register resets to debug, so core wins the first tie.
- Undefined: fixed core priority as above; last-owner register is not built.

Test Plan:
- Core write, RD_LAT=1: c_req=1, c_we=1, c_addr=0x05, c_wdata=0xDEADBEEF → next cycle m_wr=1, m_addr=0x05, m_wdata=0xDEADBEEF, c_gnt=1; c_stall=1 the first cycle and 0 in the gnt cycle.
- Core read, RD_LAT=3, m_rdata returns 0x12345678 → c_gnt at T, c_rvalid at T+4 with c_rdata=0x12345678; c_stall=1 from request until T+4.
- Simultaneous core read 0x10 and debug write 0x20, macro undefined → core granted first; d_gnt issues in the CMD cycle following core's rvalid+IDLE; debug write lands at 0x20.
- Same as above, repeated twice with DMEM_ARB_RR_EN defined → grant order core, debug, core, debug.
- Reset asserted mid-RWAIT (RD_LAT=4, cnt=2) → all outputs 0 immediately; no rvalid after release; fresh d_req read completes normally.
- Back-to-back debug writes to 0x00..0x03 with c_req=0 → d_gnt every 2nd cycle; busy toggles; memory holds all four words.
